// File: rtl/axis_pattern_gen_pkg.sv
// axis_pattern_gen_pkg: shared types and the LFSR step for the pattern generator
package axis_pattern_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  typedef enum logic [1:0] {COUNTER, WALKING_ONE, LFSR, CONSTANT} pattern_mode_t;
  function automatic logic [63:0] lfsr_next(input logic [63:0] v, input logic [63:0] taps);
    return v[0] ? (v >> 1) ^ taps : v >> 1;
  endfunction
endpackage

// File: rtl/axis_pattern_gen_if.sv
// axis_pattern_gen_if: AXI-Stream beat bus between the generator and its sink
interface axis_pattern_gen_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen_pattern_source.sv
// pattern_source: counter, walking-one and LFSR pattern state with word select
module pattern_source import axis_pattern_gen_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  reload,
  input  pattern_mode_t         mode,
  input  logic [DATA_WIDTH-1:0] const_data,
  output logic [DATA_WIDTH-1:0] word
);
  logic [DATA_WIDTH-1:0] cnt_q, walk_q, lfsr_q, cnt_d, walk_d, lfsr_d;
  // a reload is visible in the same cycle, so a packet starting with it sees the reset pattern
  always_comb begin
    cnt_d = reload ? '0 : cnt_q;
    walk_d = reload ? DATA_WIDTH'(1) : walk_q;
    lfsr_d = reload ? LFSR_SEED : lfsr_q;
    word = mode == COUNTER ? cnt_d : mode == WALKING_ONE ? walk_d : mode == LFSR ? lfsr_d : const_data;
  end
  // only the selected pattern steps; the others keep their place for later packets
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      walk_q <= DATA_WIDTH'(1);
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q <= advance && mode == COUNTER ? cnt_d + DATA_WIDTH'(1) : cnt_d;
      walk_q <= advance && mode == WALKING_ONE ? {walk_d[DATA_WIDTH-2:0], walk_d[DATA_WIDTH-1]} : walk_d;
      lfsr_q <= advance && mode == LFSR ? DATA_WIDTH'(lfsr_next(64'(lfsr_d), 64'(LFSR_TAPS))) : lfsr_d;
    end
endmodule

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: framed AXI-Stream test-pattern source with packet length and gap control
module axis_pattern_gen import axis_pattern_gen_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = 8'h01
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_data,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [LEN_WIDTH-1:0]  gap_len,
  axis_pattern_gen_if.master    m_axis,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);
  state_t state_q, state_d;
  pattern_mode_t mode_q, mode_sel;
  logic [DATA_WIDTH-1:0] const_q, const_sel, word, tdata_q;
  logic [LEN_WIDTH-1:0] len_q, beat_q, gap_q, len_in;
  logic [CNT_WIDTH-1:0] pkt_count_q;
  logic tvalid_q, tlast_q, accept, last_acc, gap_done, reload, start, step, adv;
  // start loads the first beat of a packet and relatches config; step loads the following beats
  always_comb begin
    accept = tvalid_q && m_axis.tready;
    last_acc = accept && tlast_q;
    gap_done = state_q == GAP && gap_q == LEN_WIDTH'(1);
    reload = state_q == IDLE && restart;
    start = enable && (state_q == IDLE || gap_done || (last_acc && gap_len == '0));
    step = accept && !tlast_q;
    adv = start || step;
    len_in = pkt_len == '0 ? LEN_WIDTH'(1) : pkt_len;
    mode_sel = start ? pattern_mode_t'(mode) : mode_q;
    const_sel = start ? const_data : const_q;
    state_d = start ? SEND : last_acc ? (enable ? GAP : IDLE) : gap_done ? IDLE : state_q;
  end
  // FSM, beat/gap counters and the registered AXIS outputs
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= IDLE;
      mode_q <= COUNTER;
      const_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      gap_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mode_q <= mode_sel;
        const_q <= const_data;
        len_q <= len_in;
      end
      beat_q <= start ? '0 : step ? beat_q + LEN_WIDTH'(1) : beat_q;
      gap_q <= last_acc ? gap_len : state_q == GAP ? gap_q - LEN_WIDTH'(1) : gap_q;
      tdata_q <= adv ? word : tdata_q;
      tvalid_q <= start || (tvalid_q && !last_acc);
      tlast_q <= start ? len_in == LEN_WIDTH'(1) : step ? beat_q + LEN_WIDTH'(2) == len_q : tlast_q && !last_acc;
      pkt_count_q <= reload ? '0 : last_acc ? pkt_count_q + CNT_WIDTH'(1) : pkt_count_q;
    end
  pattern_source #(.DATA_WIDTH(DATA_WIDTH), .LFSR_TAPS(LFSR_TAPS), .LFSR_SEED(LFSR_SEED)) u_src (
    .clk(sys_clk),
    .rst(sys_rst),
    .advance(adv),
    .reload(reload),
    .mode(mode_sel),
    .const_data(const_sel),
    .word(word)
  );
  assign m_axis.tdata = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast = tlast_q;
  assign busy = state_q != IDLE;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: vector table, corner-case sequences and randomized scoreboard for axis_pattern_gen
module tb_axis_pattern_gen;
  logic sys_clk, sys_rst, enable, restart, tready, busy;
  logic [1:0] mode;
  logic [7:0] const_data;
  logic [15:0] pkt_len, gap_len;
  logic [31:0] pkt_count;
  int vectors = 0, miscompares = 0;

  axis_pattern_gen_if #(.DATA_WIDTH(8)) axis();
  assign axis.tready = tready;

  axis_pattern_gen dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .restart(restart),
    .mode(mode), .const_data(const_data), .pkt_len(pkt_len), .gap_len(gap_len),
    .m_axis(axis), .busy(busy), .pkt_count(pkt_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cdata;
    logic [15:0] len;
    logic [15:0] gap;
    bit rnd;
    bit rmid;
    logic [79:0] d;
    logic [9:0] lm;
  } vec_t;
  vec_t tbl[8];

  logic [7:0] cap_d[10];
  logic cap_l[10];
  int cap_n = 0;
  bit cap_en = 0, sb_en = 0, stab_en = 0;
  logic pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = 0;

  logic [8:0] exp_q[$];
  logic [7:0] m_cnt = 8'h00, m_walk = 8'h01, m_lfsr = 8'h01;
  int m_pk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || axis.tvalid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_idle", {63'd0, busy}, 64'd0);
  endtask

  function automatic void model_reset();
    m_cnt = 8'h00;
    m_walk = 8'h01;
    m_lfsr = 8'h01;
    m_pk = 0;
    exp_q.delete();
  endfunction

  // expected beats of one packet built from the current config and the model's pattern state
  function automatic void gen_pkt();
    int len = (pkt_len == 16'd0) ? 1 : int'(pkt_len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] v;
      case (mode)
        2'd0: v = m_cnt;
        2'd1: v = m_walk;
        2'd2: v = m_lfsr;
        default: v = const_data;
      endcase
      exp_q.push_back({i == len - 1, v});
      if (mode == 2'd0) m_cnt = 8'((int'(m_cnt) + 1) % 256);
      else if (mode == 2'd1) m_walk = (m_walk == 8'h80) ? 8'h01 : 8'(int'(m_walk) * 2);
      else if (mode == 2'd2) m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 8'hB8 : m_lfsr >> 1;
    end
  endfunction

  // monitor: stall stability, beat capture and scoreboard on accepted beats
  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (stab_en && pv && !pr) begin
      chk("stall_valid", {63'd0, axis.tvalid}, 64'd1);
      chk("stall_data", {56'd0, axis.tdata}, {56'd0, pd});
      chk("stall_last", {63'd0, axis.tlast}, {63'd0, pl});
    end
    if (axis.tvalid && tready) begin
      if (cap_en && cap_n < 10) begin
        cap_d[cap_n] = axis.tdata;
        cap_l[cap_n] = axis.tlast;
        cap_n++;
      end
      if (sb_en) begin
        if (exp_q.size() == 0) gen_pkt();
        e = exp_q.pop_front();
        chk("sb_data", {56'd0, axis.tdata}, {56'd0, e[7:0]});
        chk("sb_last", {63'd0, axis.tlast}, {63'd0, e[8]});
        if (e[8]) m_pk++;
      end
    end
    pv = axis.tvalid;
    pr = tready;
    pd = axis.tdata;
    pl = axis.tlast;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, beats, lastidx;
    tbl[0] = '{2'd0, 8'h00, 16'd4, 16'd0, 1'b0, 1'b0, 80'h09080706050403020100, 10'h088};
    tbl[1] = '{2'd2, 8'h00, 16'd3, 16'd0, 1'b0, 1'b0, 80'h3264C8E1B3172E5CB801, 10'h124};
    tbl[2] = '{2'd1, 8'h00, 16'd9, 16'd0, 1'b0, 1'b0, 80'h02018040201008040201, 10'h100};
    tbl[3] = '{2'd3, 8'hA5, 16'd0, 16'd0, 1'b0, 1'b0, 80'hA5A5A5A5A5A5A5A5A5A5, 10'h3FF};
    tbl[4] = '{2'd0, 8'h00, 16'd1, 16'd2, 1'b0, 1'b0, 80'h09080706050403020100, 10'h3FF};
    tbl[5] = '{2'd1, 8'h00, 16'd2, 16'd0, 1'b0, 1'b0, 80'h02018040201008040201, 10'h2AA};
    tbl[6] = '{2'd0, 8'h00, 16'd4, 16'd0, 1'b1, 1'b0, 80'h09080706050403020100, 10'h088};
    tbl[7] = '{2'd0, 8'h00, 16'd4, 16'd0, 1'b0, 1'b1, 80'h09080706050403020100, 10'h088};

    sys_rst = 1'b1; enable = 0; restart = 0; tready = 1; mode = 0;
    const_data = 0; pkt_len = 16'd4; gap_len = 0;
    step(); step();
    chk("rst_tvalid", {63'd0, axis.tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, axis.tlast}, 64'd0);
    chk("rst_tdata", {56'd0, axis.tdata}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pkt_count", {32'd0, pkt_count}, 64'd0);
    sys_rst = 1'b0;
    step();
    stab_en = 1;

    for (int r = 0; r < 8; r++) begin
      mode = tbl[r].mode; const_data = tbl[r].cdata;
      pkt_len = tbl[r].len; gap_len = tbl[r].gap;
      restart = 1; step(); restart = 0;
      cap_n = 0; cap_en = 1; enable = 1; n = 0;
      while (cap_n < 10 && n < 300) begin
        tready = tbl[r].rnd ? 1'($urandom % 2) : 1'b1;
        restart = tbl[r].rmid && n == 3;
        step();
        n++;
      end
      restart = 0; cap_en = 0; enable = 0; tready = 1;
      chk($sformatf("row%0d_beats", r), 64'(cap_n), 64'd10);
      drain();
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("row%0d_data%0d", r, k), {56'd0, cap_d[k]}, {56'd0, tbl[r].d[8*k +: 8]});
        chk($sformatf("row%0d_last%0d", r, k), {63'd0, cap_l[k]}, {63'd0, tbl[r].lm[k]});
      end
    end

    mode = 0; pkt_len = 16'd2; gap_len = 16'd5; tready = 1;
    restart = 1; step(); restart = 0; enable = 1;
    n = 0;
    while (!(axis.tvalid && axis.tlast) && n < 50) begin step(); n++; end
    step();
    g = 0;
    while (!axis.tvalid && g < 50) begin
      chk("gap_busy", {63'd0, busy}, 64'd1);
      g++;
      step();
    end
    chk("gap_cycles", 64'(g), 64'd5);
    chk("gap_next_data", {56'd0, axis.tdata}, 64'd2);
    enable = 0;
    drain();

    mode = 0; pkt_len = 16'd8; gap_len = 0;
    restart = 1; step(); restart = 0; enable = 1;
    beats = 0; lastidx = -1; n = 0;
    while (n < 40 && lastidx < 0) begin
      step();
      n++;
      if (axis.tvalid) begin
        chk("drop_data", {56'd0, axis.tdata}, 64'(beats));
        if (beats == 1) begin enable = 0; pkt_len = 16'd2; end
        if (axis.tlast) lastidx = beats;
        beats++;
      end
    end
    chk("drop_last_idx", 64'(lastidx), 64'd7);
    step();
    chk("drop_idle_busy", {63'd0, busy}, 64'd0);
    chk("drop_idle_tvalid", {63'd0, axis.tvalid}, 64'd0);
    chk("drop_pkt_count", {32'd0, pkt_count}, 64'd1);

    pkt_len = 16'd8; enable = 1;
    step(); step(); step();
    stab_en = 0;
    #2 sys_rst = 1;
    #1;
    chk("arst_tvalid", {63'd0, axis.tvalid}, 64'd0);
    chk("arst_tlast", {63'd0, axis.tlast}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_pkt_count", {32'd0, pkt_count}, 64'd0);
    enable = 0;
    step();
    sys_rst = 0;
    step(); step();
    stab_en = 1;

    mode = 0; pkt_len = 16'd3; gap_len = 0; enable = 1;
    step(); enable = 0;
    drain();
    chk("rs_pkt_count1", {32'd0, pkt_count}, 64'd1);
    restart = 1; enable = 1;
    step();
    restart = 0; enable = 0;
    chk("rs_pkt_clear", {32'd0, pkt_count}, 64'd0);
    chk("rs_tvalid", {63'd0, axis.tvalid}, 64'd1);
    chk("rs_first_data", {56'd0, axis.tdata}, 64'd0);
    drain();
    chk("rs_pkt_count2", {32'd0, pkt_count}, 64'd1);

    sb_en = 1;
    for (int it = 0; it < 12; it++) begin
      bit do_rst;
      int cyc;
      do_rst = (it == 0) || ($urandom_range(0, 2) == 0);
      mode = 2'($urandom_range(0, 3));
      const_data = 8'($urandom);
      pkt_len = 16'($urandom_range(0, 6));
      gap_len = 16'($urandom_range(0, 3));
      restart = do_rst;
      if (do_rst) model_reset();
      step();
      restart = 0; enable = 1;
      cyc = $urandom_range(20, 60);
      for (int c = 0; c < cyc; c++) begin
        tready = 1'($urandom % 2);
        step();
      end
      enable = 0; n = 0;
      while ((busy || axis.tvalid) && n < 500) begin
        tready = 1'($urandom % 2);
        step();
        n++;
      end
      tready = 1;
      chk("rnd_idle", {63'd0, busy}, 64'd0);
      chk("rnd_queue_left", 64'(exp_q.size()), 64'd0);
      chk("rnd_pkt_count", {32'd0, pkt_count}, 64'(m_pk));
    end
    sb_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
Parametrised AXI-Stream test-pattern source for the FT232H/USB data path. It generates framed packets (tlast on the final beat) in one of four selectable patterns, with programmable packet length and inter-packet gap. It sits in the sys_clk domain and drives the programmer-side AXIS input of the ft232h FIFO bridge for link bring-up, throughput measurement and host-side integrity checking.

Parameters:
DATA_WIDTH, 8, tdata width in bits (>=2).
LEN_WIDTH, 16, width of the pkt_len and gap_len inputs.
CNT_WIDTH, 32, width of the pkt_count status counter.
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask, DATA_WIDTH bits.
LFSR_SEED, 8'h01, LFSR value loaded at reset and by restart; must be non-zero.

Ports:
sys_clk  input  1  system clock; all logic is in this domain.
sys_rst  input  1  asynchronous, active-high reset.
enable  input  1  level; while high, packets are generated back to back.
restart  input  1  one-cycle pulse; reloads the pattern state when the generator is idle.
mode  input  2  0=COUNTER, 1=WALKING_ONE, 2=LFSR, 3=CONSTANT.
const_data  input  DATA_WIDTH  payload for CONSTANT mode.
pkt_len  input  LEN_WIDTH  beats per packet; 0 is treated as 1.
gap_len  input  LEN_WIDTH  idle cycles between packets, 0 = back to back.
tdata  output  DATA_WIDTH  AXIS data.
tvalid  output  1  AXIS valid.
tready  input  1  AXIS ready from downstream (ft232h).
tlast  output  1  high on the final beat of each packet.
busy  output  1  high in SEND or GAP.
pkt_count  output  CNT_WIDTH  number of completed packets; wraps.

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, pkt_count=0, state=IDLE, counter=0, walking=1, lfsr=LFSR_SEED.
- FSM states are IDLE, SEND and GAP.
- IDLE -> SEND when enable=1. On that edge, latch mode, const_data and max(pkt_len,1) into shadow registers. The first beat is presented on the next cycle: tvalid rises one cycle after the transition.
- SEND: tvalid stays high. A beat is accepted when tvalid&&tready.
  - tdata, tlast and the pattern state must not change while tvalid=1 and tready=0 (AXIS stability).
  - On each accepted beat, the pattern state advances and the beat counter increments.
  - tlast=1 exactly when the beat counter equals the latched length - 1.
- On acceptance of the tlast beat: pkt_count increments.
  - If gap_len != 0 and enable=1: go to GAP, tvalid=0.
  - If gap_len == 0 and enable=1: relatch the config and stay in SEND with tvalid held high. There are no bubble cycles between packets.
  - If enable=0: go to IDLE, tvalid=0.
- GAP: a down-counter loaded with gap_len counts idle cycles. When it expires, go to SEND (relatching config) if enable=1, otherwise to IDLE. tvalid=0 throughout GAP.
- Deasserting enable mid-packet never truncates the packet; the current packet always completes with tlast.
- Changing mode, const_data or pkt_len mid-packet has no effect until the next packet boundary.
- Pattern state persists across packets and continues from where it stopped, so the host can detect dropped beats:
  - COUNTER: tdata = counter; increments by 1, wrapping at 2^DATA_WIDTH.
  - WALKING_ONE: rotate left by 1; bit DATA_WIDTH-1 wraps to bit 0.
  - LFSR: Galois shift right. If lsb=1, next = (lfsr>>1)^LFSR_TAPS; otherwise next = lfsr>>1. It never reaches 0.
  - CONSTANT: tdata = latched const_data; no pattern state advances.
- restart: accepted only in IDLE. It resets counter=0, walking=1 and lfsr=LFSR_SEED, and clears pkt_count. It is ignored in SEND and GAP.
- If restart and enable are both asserted in IDLE in the same cycle: restart applies first, and the packet starts with the reset pattern.
- tdata is registered; no combinational path from tready to any output.
- Asynchronous reset mid-packet drops tvalid immediately; no tlast is emitted for the aborted packet.

Decomposition:
- Package axis_pattern_gen_pkg: the state_t enum (IDLE, SEND, GAP), the pattern_mode_t enum (COUNTER, WALKING_ONE, LFSR, CONSTANT), and an lfsr_next function.
- Sub-module pattern_source: holds counter, walking and lfsr registers. Inputs: advance, reload, mode. Output: the current word.
- The top module holds the FSM, length and gap counters, AXIS registers and pkt_count.

Test Plan:
- COUNTER, pkt_len=4, gap_len=0, tready=1, enable high for 2 packets -> tdata 0,1,2,3,4,5,6,7 on consecutive cycles; tlast on beats 3 and 7; pkt_count=2.
- Same config with tready toggled randomly (50%) -> accepted sequence identical to the previous case; tdata and tlast stable during every stall.
- LFSR, seed 0x01, taps 0xB8, pkt_len=3 -> tdata 0x01,0xB8,0x5C; tlast on 0x5C. WALKING_ONE, pkt_len=9 -> 01,02,04,...,80,01.
- gap_len=5, pkt_len=2 -> exactly 5 cycles with tvalid=0 and busy=1 between the tlast beat and the next first beat.
- enable dropped on beat 1 of an 8-beat packet; pkt_len changed to 2 mid-packet -> all 8 beats sent with tlast on beat 7, then IDLE with busy=0; pkt_len=0 -> single-beat packets with tlast=1.
- Assert sys_rst mid-packet -> tvalid=0 immediately, pkt_count=0. restart while in SEND -> ignored; restart in IDLE after 3 COUNTER beats -> next packet starts at tdata=0.
